// File: rtl/key_matrix_scanner.sv
// rtl/key_matrix_scanner.sv - 5x5 button matrix scanner with frame debounce and key-change events
module key_matrix_scanner #(
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic        PIXEL_CLK,
    input  logic        I_RST_N,
    input  logic [4:0]  I_row,
    output logic [4:0]  O_col,
    output logic [24:0] O_keys,
    output logic        O_change,
    output logic [4:0]  O_key_code,
    output logic        O_key_down,
    output logic        O_any
);

    localparam int              DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]      MATCH_FULL = 4'(DEBOUNCE_FRAMES);

    logic [4:0]    row_meta;
    logic [4:0]    row_sync;
    logic [DW-1:0] dwell;
    logic [2:0]    col_idx;
    logic [24:0]   frame;
    logic [24:0]   candidate;
    logic [3:0]    match;
    logic          frame_done;
    logic [24:0]   full_frame;
    logic [24:0]   changed;
    logic [4:0]    change_idx;

    function automatic logic [4:0] lowest_bit(input logic [24:0] v);
        lowest_bit = 5'd0;
        for (int i = 24; i >= 0; i--) begin
            if (v[i]) lowest_bit = 5'(i);
        end
    endfunction

    // Column 4 is being captured this cycle, so merge it in rather than wait a cycle.
    always_comb begin
        full_frame = {row_sync, frame[19:0]};
        changed    = candidate ^ O_keys;
        change_idx = lowest_bit(changed);
    end

    always_ff @(posedge PIXEL_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            row_meta   <= '0;
            row_sync   <= '0;
            dwell      <= '0;
            col_idx    <= '0;
            O_col      <= 5'b00001;
            frame      <= '0;
            candidate  <= '0;
            match      <= '0;
            frame_done <= 1'b0;
            O_keys     <= '0;
            O_change   <= 1'b0;
            O_key_code <= '0;
            O_key_down <= 1'b0;
            O_any      <= 1'b0;
        end else begin
            row_meta   <= I_row;
            row_sync   <= row_meta;
            frame_done <= 1'b0;

            if (dwell == DWELL_LAST) begin
                dwell                 <= '0;
                frame[5*col_idx +: 5] <= row_sync;
                if (col_idx == 3'd4) begin
                    col_idx    <= '0;
                    O_col      <= 5'b00001;
                    frame_done <= 1'b1;
                    if (full_frame != candidate) begin
                        candidate <= full_frame;
                        match     <= 4'd1;
                    end else if (match != MATCH_FULL) begin
                        match <= match + 4'd1;
                    end
                end else begin
                    col_idx <= col_idx + 3'd1;
                    O_col   <= {O_col[3:0], 1'b0};
                end
            end else begin
                dwell <= dwell + 1'b1;
            end

            // Commit uses the candidate/match values settled by the capture edge just before.
            if (frame_done && match == MATCH_FULL && candidate != O_keys) begin
                O_keys     <= candidate;
                O_any      <= |candidate;
                O_change   <= 1'b1;
                O_key_code <= change_idx;
                O_key_down <= candidate[change_idx];
            end else begin
                O_change <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// tb/tb_key_matrix_scanner.sv - scoreboard bench for key_matrix_scanner
module tb_key_matrix_scanner;

    localparam int SD = 8;
    localparam int DF = 3;
    localparam int FRAME = 5 * SD;
    localparam int LATENCY = DF * FRAME + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  row;
    logic [4:0]  col;
    logic [24:0] keys;
    logic        change;
    logic [4:0]  key_code;
    logic        key_down;
    logic        any;

    logic [24:0] pressed = '0;

    typedef struct packed {
        logic [24:0] keys;
        logic [4:0]  code;
        logic        down;
        logic        any;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   events = 0;
    logic prev_change = 1'b0;

    key_matrix_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
        .PIXEL_CLK (clk),
        .I_RST_N   (rst_n),
        .I_row     (row),
        .O_col     (col),
        .O_keys    (keys),
        .O_change  (change),
        .O_key_code(key_code),
        .O_key_down(key_down),
        .O_any     (any)
    );

    always #5 clk = ~clk;

    // Button matrix: the driven column connects its five keys to the row lines.
    always_comb begin
        row = '0;
        for (int c = 0; c < 5; c++) begin
            if (col[c]) row = row | pressed[5*c +: 5];
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (change) begin
                events++;
                checks++;
                if (prev_change) begin
                    errors++;
                    $display("FAIL change_width: O_change high two cycles in a row, required single-cycle pulse");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: O_keys=%h code=%0d down=%0d, no event required", keys, key_code, key_down);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checks++;
                    if (keys !== e.keys) begin
                        errors++;
                        $display("FAIL event_keys: got %h required %h", keys, e.keys);
                    end
                    checks++;
                    if (key_code !== e.code) begin
                        errors++;
                        $display("FAIL event_code: got %0d required %0d", key_code, e.code);
                    end
                    checks++;
                    if (key_down !== e.down) begin
                        errors++;
                        $display("FAIL event_down: got %0d required %0d", key_down, e.down);
                    end
                    checks++;
                    if (any !== e.any) begin
                        errors++;
                        $display("FAIL event_any: got %0d required %0d", any, e.any);
                    end
                end
            end
            prev_change <= change;
        end else begin
            prev_change <= 1'b0;
        end
    end

    task automatic wait_frame_start(output bit found);
        logic [4:0] prev;
        found = 1'b0;
        prev = col;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (col == 5'b00001 && prev != 5'b00001) begin
                found = 1'b1;
                break;
            end
            prev = col;
        end
    endtask

    task automatic wait_change(output int n);
        n = -1;
        for (int i = 1; i <= 8 * FRAME; i++) begin
            @(negedge clk);
            if (change) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if (col !== 5'b00001 || keys !== '0 || change !== 1'b0 || key_code !== '0 || key_down !== 1'b0 || any !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: col=%b keys=%h change=%0d code=%0d down=%0d any=%0d, required 00001/0/0/0/0/0",
                     col, keys, change, key_code, key_down, any);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6 * SD; k++) begin
            logic [4:0] exp_col;
            exp_col = 5'b00001 << ((k / SD) % 5);
            checks++;
            if (col !== exp_col) begin
                errors++;
                $display("FAIL scan_col: cycle %0d got %b required %b", k, col, exp_col);
            end
            checks++;
            if (change !== 1'b0 || any !== 1'b0) begin
                errors++;
                $display("FAIL idle_outputs: cycle %0d change=%0d any=%0d required 0/0", k, change, any);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bounce;
        bit found;
        int ev0;
        ev0 = events;
        for (int f = 0; f < 10; f++) begin
            wait_frame_start(found);
            checks++;
            if (!found) begin
                errors++;
                $display("FAIL bounce_frame: frame start not seen, required within %0d cycles", 3 * FRAME);
            end
            pressed = (f % 2 == 0) ? (25'd1 << 13) : 25'd0;
            checks++;
            if (keys !== '0) begin
                errors++;
                $display("FAIL bounce_keys: got %h required 0", keys);
            end
        end
        for (int f = 0; f < 4; f++) wait_frame_start(found);
        checks++;
        if (events != ev0 || keys !== '0) begin
            errors++;
            $display("FAIL bounce_quiet: events %0d keys %h, required 0 events and keys 0", events - ev0, keys);
        end
    endtask

    task automatic run_event(input string name, input logic [24:0] new_pressed, input exp_t e);
        bit found;
        int n;
        wait_frame_start(found);
        pressed = new_pressed;
        exp_q.push_back(e);
        wait_change(n);
        checks++;
        if (!found || n != LATENCY) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles (frame seen %0d) required %0d", name, n, found, LATENCY);
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: %0d events outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_press;
        run_event("press", 25'd1 << 13, '{keys: 25'd1 << 13, code: 5'd13, down: 1'b1, any: 1'b1});
    endtask

    task automatic test_release;
        run_event("release", 25'd0, '{keys: 25'd0, code: 5'd13, down: 1'b0, any: 1'b0});
    endtask

    task automatic test_multi;
        logic [24:0] m;
        m = (25'd1 << 4) | (25'd1 << 20);
        run_event("multi", m, '{keys: m, code: 5'd4, down: 1'b1, any: 1'b1});
        for (int i = 0; i < FRAME; i++) @(negedge clk);
        checks++;
        if (key_code !== 5'd4 || key_down !== 1'b1) begin
            errors++;
            $display("FAIL multi_hold: code=%0d down=%0d required 4/1", key_code, key_down);
        end
    endtask

    task automatic test_reset_mid;
        bit found;
        int ev0;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (col == 5'b01000) begin
                found = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (!found || col !== 5'b00001 || keys !== '0 || change !== 1'b0 || key_code !== '0 || key_down !== 1'b0 || any !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: col=%b keys=%h change=%0d code=%0d down=%0d any=%0d (col3 seen %0d), required 00001/0/0/0/0/0",
                     col, keys, change, key_code, key_down, any, found);
        end
        pressed = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k <= SD; k++) begin
            logic [4:0] exp_col;
            exp_col = (k < SD) ? 5'b00001 : 5'b00010;
            checks++;
            if (col !== exp_col) begin
                errors++;
                $display("FAIL restart_col: cycle %0d got %b required %b", k, col, exp_col);
            end
            @(negedge clk);
        end
        ev0 = events;
        for (int f = 0; f < DF + 2; f++) wait_frame_start(found);
        checks++;
        if (events != ev0 || keys !== '0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset_quiet: events %0d keys %h queue %0d, required 0/0/0", events - ev0, keys, exp_q.size());
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_bounce();
        test_press();
        test_release();
        test_multi();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_matrix_scanner.md
# key_matrix_scanner

Scans a 5x5 push-button matrix and reports a debounced key map plus key-change events. It is the input-side counterpart of the 5x5 row/column LED multiplexer: the same one-hot column strobing, but here the block drives the column lines and reads back the row sense lines. It sits between the board's button matrix pins and the control logic clocked by PIXEL_CLK.

## Interface

- SCAN_DIV, default 100000, clock cycles each column is driven (1 ms at 100 MHz); legal minimum 4.
- DEBOUNCE_FRAMES, default 4, consecutive identical full frames required before a key-map change is accepted; legal range 1..15.

- PIXEL_CLK  in  1  system clock; all logic on rising edge.
- I_RST_N  in  1  reset, asynchronous assert, active-low.
- I_row  in  5  row sense lines, asynchronous; 1 = key on the driven column is closed.
- O_col  out  5  one-hot column drive; bit c high = column c driven.
- O_keys  out  25  debounced key map; bit 5*c+r = key at column c, row r is pressed.
- O_change  out  1  single-cycle pulse when O_keys updates.
- O_key_code  out  5  index (0..24) of lowest-numbered key that changed at the last update; held until the next update.
- O_key_down  out  1  1 = that key is now pressed, 0 = released; held.
- O_any  out  1  OR-reduction of O_keys.

## Operation

- I_row passes through a 2-flop synchronizer before any use.
- Dwell counter runs 0..SCAN_DIV-1; column index runs 0..4 and wraps to 0. O_col is registered, = 1 << column index.
- Cycle where dwell == SCAN_DIV-1: synchronized rows are written into frame buffer bits [5c+4:5c]; dwell reloads to 0; column index advances on the same edge.
- Frame completes on the column-4 capture. The completed frame (with column-4 bits merged) is compared with the candidate register:
  - differs: candidate <= frame, match counter <= 1.
  - equal: match counter increments, saturating at DEBOUNCE_FRAMES.
- Commit: on the next edge, if match == DEBOUNCE_FRAMES and candidate != O_keys, then O_keys <= candidate, O_change <= 1, O_key_code <= lowest set bit index of (candidate XOR O_keys before update), O_key_down <= candidate[that index]. Otherwise O_change <= 0.
- Only one event per commit; if several keys change together, O_keys carries all changes, but O_key_code/O_key_down report only the lowest index.
- O_any is registered and tracks O_keys with no additional delay, updating on the same edge.
- The frame buffer is never cleared between frames; every bit is overwritten once per frame.

## Timing

- Reset values: O_col = 5'b00001, dwell 0, column 0, synchronizer 0, frame buffer 0, candidate 0, match 0, O_keys 0, O_change 0, O_key_code 0, O_key_down 0, O_any 0.
- Reset asserted mid-scan forces all of the above immediately (async). After deassertion, the scan restarts at column 0 with a full dwell.
- Full frame period: 5*SCAN_DIV cycles.
- Sample point is the last dwell cycle. Synchronizer latency is 2 cycles, so SCAN_DIV >= 4 guarantees the sample reflects the current column.
- O_keys, O_key_code, O_key_down, O_any and O_change all change exactly 1 edge after the column-4 capture edge. O_change falls on the following edge.
- Minimum press-to-event latency, with the press present before a frame starts: DEBOUNCE_FRAMES frames + 1 cycle.
- DEBOUNCE_FRAMES = 1: every changed frame commits immediately.

## Test plan

- Reset, SCAN_DIV=8, no keys: O_col = 00001, 00010, 00100, 01000, 10000, 00001, each held 8 cycles; O_change never asserts; O_any = 0.
- Matrix model, key c=2 r=3 held, DEBOUNCE_FRAMES=3: O_change pulses once after the 3rd full frame. O_keys = bit 13 only, O_key_code = 13, O_key_down = 1, O_any = 1.
- Bounce: key 13 alternates pressed/released each frame for 10 frames (DEBOUNCE_FRAMES=3): no O_change pulse; O_keys stays 0.
- Release key 13 after the commit: after 3 stable frames, O_change pulses; O_keys = 0, O_key_code = 13, O_key_down = 0, O_any = 0.
- Keys 4 and 20 pressed in the same frame: a single pulse; O_keys = bits 4 and 20, O_key_code = 4, O_key_down = 1.
- I_RST_N pulled low mid-dwell on column 3 with O_keys nonzero: outputs return to reset values without waiting for a clock edge. After release, O_col = 00001 for a full 8 cycles.
